apb_master_bridge: RTL and testbench

APB master bridge between the testbench-facing command interface (`transfer`, `READ_WRITE`, write/read address and data) and an APB bus shared by two slaves. Latches one command per transfer, runs the APB SETUP/ACCESS sequence, decodes the slave select from the address MSB, and returns read data on `apb_read_data_out`. Sits directly downstream of the APB command interface and upstream of the two APB slave models.

---
 rtl/apb_master_bridge.sv | 174 +++++++++++++++++
 tb/tb_apb_master_bridge.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//   APB master bridge: latches one command per transfer, runs the APB
//   SETUP/ACCESS sequence towards two slaves (selected by paddr[AW-1]) and
//   returns read data on apb_read_data_out.
//
// Optional feature: define APB_TIMEOUT_EN to abandon an ACCESS phase after
//   TIMEOUT wait cycles (pslverr + done pulse together). Undefined (default):
//   ACCESS waits indefinitely and pslverr is tied low.
//
// Ports
//   pclk, presetn          clock, asynchronous active-low reset
//   transfer, READ_WRITE   command request (level) and direction (1 = read)
//   apb_write_paddr/data   write command address / data
//   apb_read_paddr         read command address
//   apb_read_data_out      data of the last completed read
//   paddr, pwrite, pwdata  APB address, direction (1 = write), write data
//   psel1, psel2, penable  APB selects (slave 1: paddr[AW-1]=0) and enable
//   prdata1/2, pready1/2   slave read data and ready
//   pslverr                one-cycle timeout error pulse
//   done                   one-cycle completion pulse
// -----------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int AW      = 9,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          transfer,
    input  logic          READ_WRITE,
    input  logic [AW-1:0] apb_write_paddr,
    input  logic [DW-1:0] apb_write_data,
    input  logic [AW-1:0] apb_read_paddr,
    output logic [DW-1:0] apb_read_data_out,
    output logic [AW-1:0] paddr,
    output logic          psel1,
    output logic          psel2,
    output logic          penable,
    output logic          pwrite,
    output logic [DW-1:0] pwdata,
    input  logic [DW-1:0] prdata1,
    input  logic [DW-1:0] prdata2,
    input  logic          pready1,
    input  logic          pready2,
    output logic          pslverr,
    output logic          done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic          pwrite_q, pwrite_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          cmd_end;
    logic          busy;
    logic          pready_sel;
    logic [DW-1:0] prdata_sel;

`ifdef APB_TIMEOUT_EN
    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pslverr_q, pslverr_d;
`endif

    // Only the addressed slave's handshake is looked at.
    assign pready_sel = paddr_q[AW-1] ? pready2 : pready1;
    assign prdata_sel = paddr_q[AW-1] ? prdata2 : prdata1;

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        cmd_end  = 1'b0;
`ifdef APB_TIMEOUT_EN
        cnt_d     = cnt_q;
        pslverr_d = 1'b0;
`endif
        case (state_q)
            // IDLE and a finished ACCESS share the same "accept next command"
            // decision below, which gives back-to-back transfers for free.
            ST_IDLE:  cmd_end = 1'b1;
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (pready_sel) begin
                    done_d  = 1'b1;
                    cmd_end = 1'b1;
                    if (!pwrite_q) rdata_d = prdata_sel;
                end
`ifdef APB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        done_d    = 1'b1;
                        pslverr_d = 1'b1;
                        cmd_end   = 1'b1;
                    end
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (cmd_end) begin
            if (transfer) begin
                state_d  = ST_SETUP;
                pwrite_d = ~READ_WRITE;
                paddr_d  = READ_WRITE ? apb_read_paddr : apb_write_paddr;
                if (!READ_WRITE) pwdata_d = apb_write_data;
`ifdef APB_TIMEOUT_EN
                cnt_d = '0;
`endif
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= ST_IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= '0;
            pslverr_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            pslverr_q <= pslverr_d;
`endif
        end
    end

    // Selects/enable decode straight from the state register so that reset
    // removes them asynchronously.
    assign busy              = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign psel1             = busy & ~paddr_q[AW-1];
    assign psel2             = busy &  paddr_q[AW-1];
    assign penable           = (state_q == ST_ACCESS);
    assign paddr             = paddr_q;
    assign pwrite            = pwrite_q;
    assign pwdata            = pwdata_q;
    assign apb_read_data_out = rdata_q;
    assign done              = done_q;

`ifdef APB_TIMEOUT_EN
    assign pslverr = pslverr_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign pslverr        = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//   Self-checking bench for apb_master_bridge. The reference model tracks, per
//   transfer, the expected bus values, the expected completion cycle
//   (2 + wait states) and the last read / last written data.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int AW = 9;
    localparam int DW = 8;

    logic          pclk = 1'b0;
    logic          presetn;
    logic          transfer;
    logic          READ_WRITE;
    logic [AW-1:0] apb_write_paddr;
    logic [DW-1:0] apb_write_data;
    logic [AW-1:0] apb_read_paddr;
    logic [DW-1:0] apb_read_data_out;
    logic [AW-1:0] paddr;
    logic          psel1, psel2, penable, pwrite;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata1, prdata2;
    logic          pready1, pready2;
    logic          pslverr, done;

    int tests = 0;
    int fails = 0;

    // Reference model state: last completed read data, last written data.
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] exp_pwdata;

    apb_master_bridge #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .pclk(pclk), .presetn(presetn), .transfer(transfer), .READ_WRITE(READ_WRITE),
        .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
        .apb_read_paddr(apb_read_paddr), .apb_read_data_out(apb_read_data_out),
        .paddr(paddr), .psel1(psel1), .psel2(psel2), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata1(prdata1), .prdata2(prdata2),
        .pready1(pready1), .pready2(pready2), .pslverr(pslverr), .done(done)
    );

    always #5 pclk = ~pclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1, "watchdog");
    end

    // Present a command on the inputs (sampled on the next rising edge).
    task automatic drive_cmd(input bit rd, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        READ_WRITE = rd;
        if (rd) begin
            apb_read_paddr  = addr;
            apb_write_paddr = AW'($urandom);
            apb_write_data  = DW'($urandom);
        end else begin
            apb_write_paddr = addr;
            apb_write_data  = wd;
            apb_read_paddr  = AW'($urandom);
        end
    endtask

    // Entered at the falling edge inside the SETUP cycle; returns at the
    // falling edge of the cycle where done is expected.
    task automatic run_xfer(input bit rd, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                            input logic [DW-1:0] rdv, input int unsigned waits, input bit from_idle,
                            input bit nxt, input bit nrd, input logic [AW-1:0] naddr,
                            input logic [DW-1:0] nwd, input string name);
        bit hi;
        hi = addr[AW-1];
        if (!rd) exp_pwdata = wd;

        tests++;
        if (psel1 !== !hi || psel2 !== hi || penable !== 1'b0) begin
            fails++;
            $display("FAIL %s setup_sel: got psel1=%b psel2=%b penable=%b, required %b %b 0",
                     name, psel1, psel2, penable, !hi, hi);
        end
        tests++;
        if (paddr !== addr || pwrite !== !rd || pwdata !== exp_pwdata) begin
            fails++;
            $display("FAIL %s setup_bus: got paddr=%h pwrite=%b pwdata=%h, required %h %b %h",
                     name, paddr, pwrite, pwdata, addr, !rd, exp_pwdata);
        end
        if (from_idle) begin
            tests++;
            if (done !== 1'b0) begin
                fails++;
                $display("FAIL %s setup_done: got done=%b, required 0", name, done);
            end
        end
        transfer = 1'($urandom);
        drive_cmd(1'($urandom), AW'($urandom), DW'($urandom));

        for (int unsigned i = 0; i <= waits; i++) begin
            @(negedge pclk);
            tests++;
            if (penable !== 1'b1 || psel1 !== !hi || psel2 !== hi || paddr !== addr ||
                pwrite !== !rd || pwdata !== exp_pwdata || done !== 1'b0) begin
                fails++;
                $display("FAIL %s access_%0d: got pen=%b s1=%b s2=%b paddr=%h pw=%b wd=%h done=%b, required 1 %b %b %h %b %h 0",
                         name, i, penable, psel1, psel2, paddr, pwrite, pwdata, done,
                         !hi, hi, addr, !rd, exp_pwdata);
            end
            // Selected slave ready only on the last ACCESS cycle; the other
            // slave drives random ready/data that must be ignored.
            if (hi) begin
                pready2 = (i == waits);
                prdata2 = (i == waits) ? rdv : DW'($urandom);
                pready1 = 1'($urandom);
                prdata1 = DW'($urandom);
            end else begin
                pready1 = (i == waits);
                prdata1 = (i == waits) ? rdv : DW'($urandom);
                pready2 = 1'($urandom);
                prdata2 = DW'($urandom);
            end
            if (i == waits) begin
                transfer = nxt;
                if (nxt) drive_cmd(nrd, naddr, nwd);
            end else begin
                transfer = 1'($urandom);
            end
        end

        @(negedge pclk);
        if (rd) exp_rdata = rdv;
        pready1 = 1'b0;
        pready2 = 1'b0;
        tests++;
        if (done !== 1'b1 || pslverr !== 1'b0) begin
            fails++;
            $display("FAIL %s done: got done=%b pslverr=%b, required 1 0", name, done, pslverr);
        end
        tests++;
        if (apb_read_data_out !== exp_rdata) begin
            fails++;
            $display("FAIL %s rdata: got %h, required %h", name, apb_read_data_out, exp_rdata);
        end
        if (!nxt) begin
            tests++;
            if (psel1 !== 1'b0 || psel2 !== 1'b0 || penable !== 1'b0) begin
                fails++;
                $display("FAIL %s idle_after: got psel1=%b psel2=%b penable=%b, required 0 0 0",
                         name, psel1, psel2, penable);
            end
        end
        transfer = 1'b0;
    endtask

    // Start a transfer from IDLE and run it to completion.
    task automatic single(input bit rd, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [DW-1:0] rdv, input int unsigned waits, input string name);
        transfer = 1'b1;
        drive_cmd(rd, addr, wd);
        @(negedge pclk);
        run_xfer(rd, addr, wd, rdv, waits, 1'b1, 1'b0, 1'b0, '0, '0, name);
        @(negedge pclk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL %s done_pulse: got done=%b one cycle later, required 0", name, done);
        end
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        transfer = 1'b0;
        READ_WRITE = 1'b0;
        apb_write_paddr = '0; apb_write_data = '0; apb_read_paddr = '0;
        prdata1 = '0; prdata2 = '0; pready1 = 1'b0; pready2 = 1'b0;
        exp_rdata = '0; exp_pwdata = '0;
        #12;
        tests++;
        if ({paddr, pwdata, apb_read_data_out, psel1, psel2, penable, pwrite, done, pslverr} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got paddr=%h pwdata=%h rdata=%h s1=%b s2=%b pen=%b pw=%b done=%b err=%b, required all 0",
                     paddr, pwdata, apb_read_data_out, psel1, psel2, penable, pwrite, done, pslverr);
        end
        @(negedge pclk);
        presetn = 1'b1;
        pready1 = 1'b1;
        pready2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            tests++;
            if (psel1 !== 1'b0 || psel2 !== 1'b0 || penable !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle_%0d: got s1=%b s2=%b pen=%b done=%b, required 0 0 0 0",
                         i, psel1, psel2, penable, done);
            end
        end
        pready1 = 1'b0;
        pready2 = 1'b0;
    endtask

    task automatic test_write_zero_wait();
        single(1'b0, 9'h012, 8'hA5, 8'h00, 0, "write_s1");
    endtask

    task automatic test_read_waits();
        single(1'b1, 9'h105, 8'h00, 8'h3C, 3, "read_s2_w3");
    endtask

    task automatic test_back_to_back();
        transfer = 1'b1;
        drive_cmd(1'b0, 9'h020, 8'h5A);
        @(negedge pclk);
        run_xfer(1'b0, 9'h020, 8'h5A, 8'h00, 0, 1'b1, 1'b1, 1'b1, 9'h120, 8'h00, "b2b_write");
        run_xfer(1'b1, 9'h120, 8'h00, 8'hC7, 0, 1'b0, 1'b0, 1'b0, '0, '0, "b2b_read");
        @(negedge pclk);
    endtask

    task automatic test_random();
        bit rd, nrd, nxt;
        logic [AW-1:0] addr, naddr;
        logic [DW-1:0] wd, nwd;
        bit from_idle;
        rd = 1'($urandom); addr = AW'($urandom); wd = DW'($urandom);
        transfer = 1'b1;
        drive_cmd(rd, addr, wd);
        @(negedge pclk);
        from_idle = 1'b1;
        for (int n = 0; n < 24; n++) begin
            nxt = (n != 23) && 1'($urandom);
            nrd = 1'($urandom); naddr = AW'($urandom); nwd = DW'($urandom);
            run_xfer(rd, addr, wd, DW'($urandom), $urandom_range(0, 3), from_idle,
                     nxt, nrd, naddr, nwd, "random");
            if (!nxt && n != 23) begin
                transfer = 1'b1;
                drive_cmd(nrd, naddr, nwd);
                @(negedge pclk);
            end
            from_idle = !nxt;
            rd = nrd; addr = naddr; wd = nwd;
        end
        @(negedge pclk);
    endtask

    task automatic test_reset_mid_access();
        transfer = 1'b1;
        drive_cmd(1'b1, 9'h044, 8'h00);
        @(negedge pclk);
        transfer = 1'b0;
        pready1 = 1'b0;
        prdata1 = 8'hEE;
        @(negedge pclk);
        tests++;
        if (penable !== 1'b1 || psel1 !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_pre: got pen=%b s1=%b, required 1 1", penable, psel1);
        end
        #2 presetn = 1'b0;
        #1;
        exp_rdata = '0;
        exp_pwdata = '0;
        tests++;
        if (psel1 !== 1'b0 || psel2 !== 1'b0 || penable !== 1'b0 || done !== 1'b0 ||
            apb_read_data_out !== exp_rdata) begin
            fails++;
            $display("FAIL rst_mid: got s1=%b s2=%b pen=%b done=%b rdata=%h, required 0 0 0 0 %h",
                     psel1, psel2, penable, done, apb_read_data_out, exp_rdata);
        end
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        tests++;
        if (done !== 1'b0 || psel1 !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_after: got done=%b s1=%b, required 0 0", done, psel1);
        end
    endtask

    task automatic test_timeout();
        transfer = 1'b1;
        drive_cmd(1'b1, 9'h033, 8'h00);
        @(negedge pclk);
        transfer = 1'b0;
        pready1 = 1'b0;
        pready2 = 1'b1;
        prdata1 = 8'h99;
`ifdef APB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            tests++;
            if (penable !== 1'b1 || done !== 1'b0 || pslverr !== 1'b0) begin
                fails++;
                $display("FAIL timeout_wait_%0d: got pen=%b done=%b err=%b, required 1 0 0",
                         i, penable, done, pslverr);
            end
        end
        @(negedge pclk);
        tests++;
        if (done !== 1'b1 || pslverr !== 1'b1 || psel1 !== 1'b0 || penable !== 1'b0 ||
            apb_read_data_out !== exp_rdata) begin
            fails++;
            $display("FAIL timeout_hit: got done=%b err=%b s1=%b pen=%b rdata=%h, required 1 1 0 0 %h",
                     done, pslverr, psel1, penable, apb_read_data_out, exp_rdata);
        end
        @(negedge pclk);
        tests++;
        if (done !== 1'b0 || pslverr !== 1'b0) begin
            fails++;
            $display("FAIL timeout_pulse: got done=%b err=%b, required 0 0", done, pslverr);
        end
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            tests++;
            if (penable !== 1'b1 || psel1 !== 1'b1 || done !== 1'b0 || pslverr !== 1'b0) begin
                fails++;
                $display("FAIL no_timeout_%0d: got pen=%b s1=%b done=%b err=%b, required 1 1 0 0",
                         i, penable, psel1, done, pslverr);
            end
        end
        // Stuck access can only be left through reset.
        presetn = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        exp_rdata = '0;
        exp_pwdata = '0;
`endif
        pready2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_waits();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
